calc_alu: RTL and testbench

- Multi-cycle BCD floating-point arithmetic unit.
- Responder end of the controller's ALU valid/ready interface.
- Accepts two calc_pkg::num_t operands and a calc_pkg::op_t (ADD, SUB, MUL, DIV).
- Iterates over NumDigits-wide combinational BCD add/subtract slices, normalizes the result, and holds it until the controller consumes it.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_alu_if.sv | 24 ++
 rtl/calc_alu.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_calc_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the BCD calculator datapath: operand/result format and ALU opcodes.
package calc_pkg;

  parameter int NumDigits = 8;
  parameter int ExpWidth  = 8;

  // value = digits[N-1].digits[N-2]...digits[0] x 10^exponent
  typedef struct packed {
    logic signed [ExpWidth-1:0]   exponent;
    logic [NumDigits-1:0][3:0]    digits;
  } num_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } op_t;

endpackage

// File: rtl/calc_alu_if.sv
// Controller <-> ALU request/response bundle; signal names are from the ALU's point of view.
interface calc_alu_if;

  calc_pkg::num_t left_i;
  calc_pkg::num_t right_i;
  calc_pkg::op_t  op_i;
  logic           in_valid_i;
  logic           in_ready_o;
  calc_pkg::num_t result_o;
  logic           error_o;
  logic           out_valid_o;
  logic           out_ready_i;

  modport slave (
    input  left_i, right_i, op_i, in_valid_i, out_ready_i,
    output in_ready_o, result_o, error_o, out_valid_o
  );

  modport master (
    output left_i, right_i, op_i, in_valid_i, out_ready_i,
    input  in_ready_o, result_o, error_o, out_valid_o
  );

endinterface

// File: rtl/calc_alu.sv
// Multi-cycle BCD floating-point ALU: align, iterate BCD add/subtract slices, normalize.
// One operation in flight; the result is held in DONE until the consumer accepts it.
module calc_alu
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input logic       clk_i,
  input logic       rst_i,
  calc_alu_if.slave bus
);

  localparam int N  = NumDigits;
  localparam int W  = 2 * N;
  localparam int EW = ExpWidth;
  localparam int XW = ExpWidth + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic signed [XW-1:0] XOne = XW'(1);
  localparam logic signed [XW-1:0] EMax = XW'(N - 1);
  localparam logic signed [XW-1:0] EMin = XW'(1 - N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_EXEC,
    S_NORM,
    S_DONE
  } state_e;

  function automatic logic [W*4:0] bcd_add(input logic [W*4-1:0] a, input logic [W*4-1:0] b);
    logic [4:0]     s;
    logic           c;
    logic [W*4-1:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < W; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // Caller guarantees a >= b, so no final borrow is produced.
  function automatic logic [W*4-1:0] bcd_sub(input logic [W*4-1:0] a, input logic [W*4-1:0] b);
    logic [4:0]     s;
    logic           bw;
    logic [W*4-1:0] r;
    bw = 1'b0;
    r  = '0;
    for (int i = 0; i < W; i++) begin
      s = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, bw};
      if (s[4]) begin
        s  = s + 5'd10;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  op_t                   op_q, op_d;
  logic [N*4-1:0]        ma_q, ma_d;
  logic [N*4-1:0]        mb_q, mb_d;
  logic signed [XW-1:0]  ea_q, ea_d;
  logic signed [XW-1:0]  eb_q, eb_d;
  logic [W*4-1:0]        acc_q, acc_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [3:0]            rep_q, rep_d;
  num_t                  res_q, res_d;
  logic                  err_q, err_d;

  logic [W*4-1:0]        ma_w, mb_w;
  logic [W*4:0]          sum_n, sum_w;
  logic [W*4-1:0]        dif_n, dif_w;
  logic [3:0]            mul_dig;
  logic                  unused_ok;

  assign ma_w  = {{((W - N) * 4){1'b0}}, ma_q};
  assign mb_w  = {{((W - N) * 4){1'b0}}, mb_q};
  assign sum_n = bcd_add(ma_w, mb_w);
  assign sum_w = bcd_add(acc_q, ma_w);
  assign dif_n = bcd_sub(ma_w, mb_w);
  assign dif_w = bcd_sub(acc_q, mb_w);
  assign unused_ok = ^{sum_w[W*4], sum_n[W*4:N*4+4], dif_n[W*4-1:N*4]};

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.result_o    = res_q;
  assign bus.error_o     = err_q;

  // Multiplier digit for the current MUL step; rem_q counts down from N (MSD first).
  always_comb begin
    mul_dig = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (rem_q == CW'(i + 1)) mul_dig = mb_q[i*4 +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    rep_d   = rep_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          op_d  = bus.op_i;
          ma_d  = bus.left_i.digits;
          mb_d  = bus.right_i.digits;
          ea_d  = {{(XW - EW){bus.left_i.exponent[EW-1]}}, bus.left_i.exponent};
          eb_d  = {{(XW - EW){bus.right_i.exponent[EW-1]}}, bus.right_i.exponent};
          rem_d = CW'(N);
          rep_d = 4'd0;
          err_d = 1'b0;
          acc_d = (bus.op_i == OP_DIV) ? {{((W - N) * 4){1'b0}}, bus.left_i.digits} : '0;
          case (bus.op_i)
            OP_ADD, OP_SUB: state_d = S_ALIGN;
            OP_MUL, OP_DIV: state_d = S_EXEC;
            default: begin
              err_d   = 1'b1;
              res_d   = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end

      // A mantissa shifted to zero just adopts the other exponent.
      S_ALIGN: begin
        if (ea_q == eb_q) begin
          state_d = S_EXEC;
        end else if (ea_q < eb_q) begin
          if (ma_q == '0) ea_d = eb_q;
          else begin
            ma_d = ma_q >> 4;
            ea_d = ea_q + XOne;
          end
        end else begin
          if (mb_q == '0) eb_d = ea_q;
          else begin
            mb_d = mb_q >> 4;
            eb_d = eb_q + XOne;
          end
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            if (sum_n[N*4 +: 4] != 4'd0) begin
              ma_d = sum_n[N*4+3:4];
              ea_d = ea_q + XOne;
            end else begin
              ma_d = sum_n[N*4-1:0];
            end
            state_d = S_NORM;
          end
          OP_SUB: begin
            if (ma_q < mb_q) begin
              err_d   = 1'b1;
              res_d   = '0;
              state_d = S_DONE;
            end else begin
              ma_d    = dif_n[N*4-1:0];
              state_d = S_NORM;
            end
          end
          OP_MUL: begin
            if (rep_q != 4'd0) begin
              acc_d = sum_w[W*4-1:0];
              rep_d = rep_q - 4'd1;
            end else if (rem_q != '0) begin
              acc_d = {acc_q[W*4-5:0], 4'h0};
              rep_d = mul_dig;
              rem_d = rem_q - CW'(1);
            end else begin
              if (acc_q[W*4-1 -: 4] != 4'd0) begin
                ma_d = acc_q[W*4-1 -: N*4];
                ea_d = ea_q + eb_q + XOne;
              end else begin
                ma_d = acc_q[W*4-5 -: N*4];
                ea_d = ea_q + eb_q;
              end
              state_d = S_NORM;
            end
          end
          OP_DIV: begin
            // Quotient digits shift into ma_q; the left operand lives on in acc_q.
            if (mb_q == '0) begin
              err_d   = 1'b1;
              res_d   = '0;
              state_d = S_DONE;
            end else if (acc_q >= mb_w && rep_q != 4'd9) begin
              acc_d = dif_w;
              rep_d = rep_q + 4'd1;
            end else begin
              ma_d  = {ma_q[N*4-5:0], rep_q};
              acc_d = {acc_q[W*4-5:0], 4'h0};
              rep_d = 4'd0;
              rem_d = rem_q - CW'(1);
              if (rem_q == CW'(1)) begin
                ea_d    = ea_q - eb_q;
                state_d = S_NORM;
              end
            end
          end
          default: begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
          end
        endcase
      end

      S_NORM: begin
        if (ma_q == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else if (ma_q[N*4-1 -: 4] == 4'd0) begin
          ma_d = {ma_q[N*4-5:0], 4'h0};
          ea_d = ea_q - XOne;
        end else if (ea_q > EMax) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_DONE;
        end else if (ea_q < EMin) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          res_d   = {ea_q[EW-1:0], ma_q};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      ma_q    <= '0;
      mb_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      rep_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      rep_q   <= rep_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: expected results queued at request time, popped on response.
module tb_calc_alu;
  import calc_pkg::*;

  typedef struct {
    num_t res;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  calc_alu_if alu_if();

  calc_alu dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (alu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic num_t mk(input logic [31:0] d, input int e);
    num_t n;
    n.digits   = d;
    n.exponent = 8'(e);
    return n;
  endfunction

  task automatic send(input string tag, input num_t l, input num_t r, input op_t op,
                      input num_t exp_res, input logic exp_err);
    exp_t e;
    int   cyc;
    e.res = exp_res;
    e.err = exp_err;
    sb_q.push_back(e);
    alu_if.left_i     = l;
    alu_if.right_i    = r;
    alu_if.op_i       = op;
    alu_if.in_valid_i = 1'b1;
    cyc = 0;
    while (!alu_if.in_ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accept"}, 64'(alu_if.in_ready_o), 64'(1));
    @(negedge clk);
    alu_if.in_valid_i = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   cyc;
    num_t first_res;
    logic first_err;
    cyc = 0;
    while (!alu_if.out_valid_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, 64'(alu_if.out_valid_o), 64'(1));
    e = sb_q.pop_front();
    check({tag, "_result"}, 64'(alu_if.result_o), 64'(e.res));
    check({tag, "_error"}, 64'(alu_if.error_o), 64'(e.err));
    first_res = alu_if.result_o;
    first_err = alu_if.error_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, 64'(alu_if.result_o), 64'(first_res));
      check({tag, "_hold_error"}, 64'(alu_if.error_o), 64'(first_err));
      check({tag, "_hold_valid"}, 64'(alu_if.out_valid_o), 64'(1));
      check({tag, "_hold_in_ready"}, 64'(alu_if.in_ready_o), 64'(0));
    end
    alu_if.out_ready_i = 1'b1;
    @(negedge clk);
    alu_if.out_ready_i = 1'b0;
    check({tag, "_post_valid"}, 64'(alu_if.out_valid_o), 64'(0));
    check({tag, "_post_in_ready"}, 64'(alu_if.in_ready_o), 64'(1));
  endtask

  initial begin
    int          a, b, s;
    logic [31:0] d;

    alu_if.left_i      = '0;
    alu_if.right_i     = '0;
    alu_if.op_i        = OP_ADD;
    alu_if.in_valid_i  = 1'b0;
    alu_if.out_ready_i = 1'b0;

    #1;
    check("rst_in_ready", 64'(alu_if.in_ready_o), 64'(1));
    check("rst_out_valid", 64'(alu_if.out_valid_o), 64'(0));
    check("rst_result", 64'(alu_if.result_o), 64'(0));
    check("rst_error", 64'(alu_if.error_o), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send("add", mk(32'h1200_0000, 1), mk(32'h7500_0000, 0), OP_ADD, mk(32'h1950_0000, 1), 1'b0);
    collect("add", 0);
    send("add_carry", mk(32'h9000_0000, 0), mk(32'h1000_0000, 0), OP_ADD, mk(32'h1000_0000, 1), 1'b0);
    collect("add_carry", 0);
    send("add_trunc", mk(32'h1000_0000, 0), mk(32'h1234_5678, -3), OP_ADD, mk(32'h1001_2345, 0), 1'b0);
    collect("add_trunc", 0);
    send("sub_zero", mk(32'h5000_0000, 0), mk(32'h5000_0000, 0), OP_SUB, mk(32'h0, 0), 1'b0);
    collect("sub_zero", 0);
    send("sub_neg", mk(32'h3000_0000, 0), mk(32'h4000_0000, 0), OP_SUB, mk(32'h0, 0), 1'b1);
    collect("sub_neg", 0);
    send("sub_norm", mk(32'h1200_0000, 1), mk(32'h1100_0000, 1), OP_SUB, mk(32'h1000_0000, 0), 1'b0);
    collect("sub_norm", 0);
    send("mul", mk(32'h2500_0000, 1), mk(32'h4000_0000, 0), OP_MUL, mk(32'h1000_0000, 2), 1'b0);
    collect("mul", 0);
    send("mul_ovf", mk(32'h9999_9999, 7), mk(32'h9999_9999, 7), OP_MUL, mk(32'h0, 0), 1'b1);
    collect("mul_ovf", 0);
    send("mul_unf", mk(32'h1000_0000, -7), mk(32'h1000_0000, -7), OP_MUL, mk(32'h0, 0), 1'b0);
    collect("mul_unf", 0);
    send("div", mk(32'h1000_0000, 0), mk(32'h4000_0000, 0), OP_DIV, mk(32'h2500_0000, -1), 1'b0);
    collect("div", 0);
    send("div_zero", mk(32'h6000_0000, 0), mk(32'h0, 0), OP_DIV, mk(32'h0, 0), 1'b1);
    collect("div_zero", 0);
    send("bad_op", mk(32'h1000_0000, 0), mk(32'h1000_0000, 0), op_t'(3'd6), mk(32'h0, 0), 1'b1);
    collect("bad_op", 0);

    // Backpressure: result must hold for 5 cycles with out_ready low.
    send("bp", mk(32'h2500_0000, 1), mk(32'h4000_0000, 0), OP_MUL, mk(32'h1000_0000, 2), 1'b0);
    collect("bp", 5);

    // Requests offered while a MUL is running are ignored.
    send("busy", mk(32'h2500_0000, 1), mk(32'h4000_0000, 0), OP_MUL, mk(32'h1000_0000, 2), 1'b0);
    alu_if.left_i     = mk(32'h3000_0000, 0);
    alu_if.right_i    = mk(32'h3000_0000, 0);
    alu_if.op_i       = OP_ADD;
    alu_if.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("busy_in_ready", 64'(alu_if.in_ready_o), 64'(0));
      @(negedge clk);
    end
    alu_if.in_valid_i = 1'b0;
    collect("busy", 0);

    // Small integer adds against a simple decimal model.
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(1, 9);
      b = $urandom_range(1, 9);
      s = a + b;
      d = (s >= 10) ? (32'h1000_0000 | (32'(s - 10) << 24)) : (32'(s) << 28);
      send("rand_add", mk(32'(a) << 28, 0), mk(32'(b) << 28, 0), OP_ADD, mk(d, (s >= 10) ? 1 : 0), 1'b0);
      collect("rand_add", 0);
    end

    // Asynchronous reset in the middle of a long MUL abandons it.
    send("rst_mul", mk(32'h9999_9999, 0), mk(32'h9999_9999, 0), OP_MUL, mk(32'h0, 0), 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(alu_if.in_ready_o), 64'(1));
    check("rst_mid_out_valid", 64'(alu_if.out_valid_o), 64'(0));
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_valid", 64'(alu_if.out_valid_o), 64'(0));
    send("post_rst", mk(32'h2000_0000, 0), mk(32'h2000_0000, 0), OP_ADD, mk(32'h4000_0000, 0), 1'b0);
    collect("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
